// File: rtl/sram_array.sv
// rtl/sram_array.sv - 1R1W synchronous SRAM with hardware init, read-valid, optional output stage and write bypass
module sram_array #(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    OUT_REG    = 0,
  parameter int                    BYPASS     = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  init_done,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] wmask
);

  localparam int                    DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [0:0]            ST_INIT   = 1'b0;
  localparam logic [0:0]            ST_READY  = 1'b1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  always_comb begin
    rd_acc    = (state == ST_READY) && rd_en;
    wr_acc    = (state == ST_READY) && wr_en;
    wr_merged = (mem[waddr] & ~wmask) | (din & wmask);
    rd_data   = mem[raddr];
    // On a same-address collision wr_merged is exactly the post-write value of the read entry
    if ((BYPASS != 0) && wr_acc && (raddr == waddr)) begin
      rd_data = wr_merged;
    end
  end

  // Array has no reset term: contents survive a reset and are rewritten by INIT
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (state == ST_INIT) begin
        mem[init_cnt] <= INIT_VALUE;
      end else if (wr_acc) begin
        mem[waddr] <= wr_merged;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
      s1_valid  <= 1'b0;
      s1_data   <= '0;
    end else begin
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 1'b1;
        if (init_cnt == LAST_ADDR) begin
          state     <= ST_READY;
          init_done <= 1'b1;
        end
      end
      s1_valid <= rd_acc;
      if (rd_acc) begin
        s1_data <= rd_data;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  s2_valid;
      logic [DATA_WIDTH-1:0] s2_data;

      always_ff @(posedge clock) begin
        if (!reset_n) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign rd_valid = s2_valid;
      assign dout     = s2_data;
    end else begin : g_no_out_reg
      assign rd_valid = s1_valid;
      assign dout     = s1_data;
    end
  endgenerate

endmodule

// File: tb/tb_sram_array.sv
// tb/tb_sram_array.sv - directed bench for sram_array, latency-1 bypass and latency-2 no-bypass instances
module tb_sram_array;

  localparam int DW = 64;
  localparam int AW = 4;
  localparam logic [DW-1:0] IV = 64'hA5;

  logic          clock;
  logic          reset_n;
  logic          rd_en;
  logic [AW-1:0] raddr;
  logic          wr_en;
  logic [AW-1:0] waddr;
  logic [DW-1:0] din;
  logic [DW-1:0] wmask;

  logic          init_done0, rd_valid0;
  logic [DW-1:0] dout0;
  logic          init_done1, rd_valid1;
  logic [DW-1:0] dout1;

  int n_checks = 0;
  int n_fails  = 0;

  sram_array #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0), .BYPASS(1), .INIT_VALUE(IV)) dut0 (
    .clock(clock), .reset_n(reset_n), .init_done(init_done0),
    .rd_en(rd_en), .raddr(raddr), .rd_valid(rd_valid0), .dout(dout0),
    .wr_en(wr_en), .waddr(waddr), .din(din), .wmask(wmask)
  );

  sram_array #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(1), .BYPASS(0), .INIT_VALUE(IV)) dut1 (
    .clock(clock), .reset_n(reset_n), .init_done(init_done1),
    .rd_en(rd_en), .raddr(raddr), .rd_valid(rd_valid1), .dout(dout1),
    .wr_en(wr_en), .waddr(waddr), .din(din), .wmask(wmask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    wr_en = 1'b1; waddr = a; din = d; wmask = m;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; rd_en = 1'b0; raddr = '0; wr_en = 1'b0; waddr = '0; din = '0; wmask = '0;
    tick(); tick();
    check("rst_init_done0", {63'd0, init_done0}, 64'd0);
    check("rst_init_done1", {63'd0, init_done1}, 64'd0);
    check("rst_rd_valid0", {63'd0, rd_valid0}, 64'd0);
    check("rst_rd_valid1", {63'd0, rd_valid1}, 64'd0);
    check("rst_dout0", dout0, 64'd0);
    check("rst_dout1", dout1, 64'd0);

    // first init, aborted after 7 cycles; ops during it must be ignored
    reset_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      wr_en = (i == 3); waddr = 4'd2; din = 64'h3C; wmask = '1;
      rd_en = (i == 4); raddr = 4'd2;
      tick();
      check("init_a_rd_valid0", {63'd0, rd_valid0}, 64'd0);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wr_en = (i == 5); waddr = 4'd2; din = 64'h3C; wmask = '1;
      rd_en = (i == 6); raddr = 4'd2;
      tick();
      if (i == 7) begin
        check("init_b_rd_valid0", {63'd0, rd_valid0}, 64'd0);
        check("init_b_rd_valid1", {63'd0, rd_valid1}, 64'd0);
        check("init_b_dout0", dout0, 64'd0);
      end
      if (i == 15) begin
        check("init_done0_c15", {63'd0, init_done0}, 64'd0);
        check("init_done1_c15", {63'd0, init_done1}, 64'd0);
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    check("init_done0_c16", {63'd0, init_done0}, 64'd1);
    check("init_done1_c16", {63'd0, init_done1}, 64'd1);

    // read every entry back-to-back
    for (int a = 0; a < 16; a++) begin
      rd_en = 1'b1; raddr = AW'(a);
      tick();
      check($sformatf("sweep0_v%0d", a), {63'd0, rd_valid0}, 64'd1);
      check($sformatf("sweep0_d%0d", a), dout0, IV);
      check($sformatf("sweep1_v%0d", a), {63'd0, rd_valid1}, (a == 0) ? 64'd0 : 64'd1);
      if (a > 0) check($sformatf("sweep1_d%0d", a - 1), dout1, IV);
    end
    rd_en = 1'b0;
    tick();
    check("sweep0_v_end", {63'd0, rd_valid0}, 64'd0);
    check("sweep1_v15", {63'd0, rd_valid1}, 64'd1);
    check("sweep1_d15", dout1, IV);
    tick();
    check("sweep1_v_end", {63'd0, rd_valid1}, 64'd0);

    // masked writes, including an all-zero mask
    write(4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    write(4'd3, 64'h0, 64'h0000_0000_FFFF_FFFF);
    write(4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    rd_en = 1'b1; raddr = 4'd3;
    tick();
    check("mask0_d3", dout0, 64'hFFFF_FFFF_0000_0000);
    raddr = 4'd4;
    tick();
    rd_en = 1'b0;
    check("mask1_d3", dout1, 64'hFFFF_FFFF_0000_0000);
    check("mask0_d4", dout0, IV);
    tick();
    check("mask1_d4", dout1, IV);

    // same-cycle collision on entry 5, then a plain follow-up read
    write(4'd5, 64'h11, '1);
    wr_en = 1'b1; waddr = 4'd5; din = 64'h22; wmask = '1;
    rd_en = 1'b1; raddr = 4'd5;
    tick();
    wr_en = 1'b0;
    check("coll0_bypass", dout0, 64'h22);
    tick();
    rd_en = 1'b0;
    check("coll0_after", dout0, 64'h22);
    check("coll1_old", dout1, 64'h11);
    tick();
    check("coll1_after", dout1, 64'h22);

    // partial-mask collision: bypass returns the merged word
    wr_en = 1'b1; waddr = 4'd5; din = 64'hF0F0; wmask = 64'hFF00;
    rd_en = 1'b1; raddr = 4'd5;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("coll0_partial", dout0, 64'hF022);
    tick();
    check("coll1_partial_old", dout1, 64'h22);

    // ordered back-to-back reads through the two-stage pipe
    write(4'd0, 64'h100, '1);
    write(4'd1, 64'h101, '1);
    write(4'd2, 64'h102, '1);
    tick();
    rd_en = 1'b1; raddr = 4'd0;
    tick();
    check("lat1_v_t1", {63'd0, rd_valid1}, 64'd0);
    check("lat0_d0", dout0, 64'h100);
    raddr = 4'd1;
    tick();
    check("lat1_v_t2", {63'd0, rd_valid1}, 64'd1);
    check("lat1_d0", dout1, 64'h100);
    check("lat0_d1", dout0, 64'h101);
    raddr = 4'd2;
    tick();
    rd_en = 1'b0;
    check("lat1_v_t3", {63'd0, rd_valid1}, 64'd1);
    check("lat1_d1", dout1, 64'h101);
    check("lat0_d2", dout0, 64'h102);
    tick();
    check("lat1_v_t4", {63'd0, rd_valid1}, 64'd1);
    check("lat1_d2", dout1, 64'h102);
    check("lat0_v_idle", {63'd0, rd_valid0}, 64'd0);
    check("lat0_hold", dout0, 64'h102);
    tick();
    check("lat1_v_t5", {63'd0, rd_valid1}, 64'd0);
    check("lat1_hold", dout1, 64'h102);

    // reset while a read is in flight
    rd_en = 1'b1; raddr = 4'd1;
    tick();
    rd_en = 1'b0; reset_n = 1'b0;
    tick();
    check("rst_ready_v0", {63'd0, rd_valid0}, 64'd0);
    check("rst_ready_v1", {63'd0, rd_valid1}, 64'd0);
    check("rst_ready_done0", {63'd0, init_done0}, 64'd0);
    check("rst_ready_dout1", dout1, 64'd0);
    tick();
    check("rst_ready_v1_late", {63'd0, rd_valid1}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
